// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and op classification for alu_seq.
// ALU_SEQ_DIV_EN selects whether DIVU/REMU use the iterative divider.
package alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL   = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA   = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
    localparam logic [OP_W-1:0] OP_MUL   = 4'b1000;
    localparam logic [OP_W-1:0] OP_MULHU = 4'b1001;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'b1010;
    localparam logic [OP_W-1:0] OP_REMU  = 4'b1011;
    localparam logic [OP_W-1:0] OP_NOR   = 4'b1100;
    localparam logic [OP_W-1:0] OP_NAND  = 4'b1101;
    localparam logic [OP_W-1:0] OP_SNE   = 4'b1110;
    localparam logic [OP_W-1:0] OP_SRL   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ops that run on the multi-cycle datapath.
    function automatic logic is_iterative(input logic [OP_W-1:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL) || (op == OP_MULHU);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared shift-add multiplier / restoring divider, one step per cycle.
// Divider half is present only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 2);

    logic [WIDTH-1:0]   hi_q, lo_q, b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               running_q, done_q;
    logic [2*WIDTH-1:0] cur, nxt;
    logic [WIDTH-1:0]   dv;
    logic [WIDTH:0]     sum_t;
    logic               load;
`ifdef ALU_SEQ_DIV_EN
    logic               div_q, div_sel;
    logic [WIDTH:0]     rem_t;
`endif

    assign load = start && is_iterative(op);

    // One iteration; the first is applied directly to the incoming operands.
    always_comb begin
        cur   = load ? {WIDTH'(0), a} : {hi_q, lo_q};
        dv    = load ? b : b_q;
        nxt   = cur;
        sum_t = '0;
`ifdef ALU_SEQ_DIV_EN
        div_sel = load ? ((op == OP_DIVU) || (op == OP_REMU)) : div_q;
        rem_t   = {cur[2*WIDTH-1:WIDTH], cur[WIDTH-1]};
        if (div_sel) begin
            if (rem_t >= {1'b0, dv}) begin
                rem_t = rem_t - {1'b0, dv};
                nxt   = {rem_t[WIDTH-1:0], cur[WIDTH-2:0], 1'b1};
            end else begin
                nxt   = {rem_t[WIDTH-1:0], cur[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        begin
            sum_t = {1'b0, cur[2*WIDTH-1:WIDTH]} + (cur[0] ? {1'b0, dv} : (WIDTH+1)'(0));
            nxt   = {sum_t, cur[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q     <= 1'b0;
`endif
        end else if (load) begin
            {hi_q, lo_q} <= nxt;
            b_q          <= b;
            cnt_q        <= '0;
            running_q    <= 1'b1;
            done_q       <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q        <= div_sel;
`endif
        end else if (running_q) begin
            {hi_q, lo_q} <= nxt;
            cnt_q        <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
                running_q <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith plus iterative mul/div.
// Define ALU_SEQ_DIV_EN to enable the DIVU/REMU divider.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  ALU_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, cout_q, ovf_q, out_valid_q, busy_q;

    logic             accept, finish, new_iter;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi, iter_res;
    logic [WIDTH:0]   add_w, sub_w;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero, alu_cout, alu_ovf;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign new_iter = is_iterative(ALU_control);
    assign finish   = (state_q == BUSY) && (count_q == LAST) && iter_done;

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (accept),
        .op    (ALU_control),
        .a     (src1),
        .b     (src2),
        .done  (iter_done),
        .lo    (iter_lo),
        .hi    (iter_hi)
    );

    // Quotient and low product live in lo; remainder and high product in hi.
    assign iter_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? iter_lo : iter_hi;

    // Single-cycle ops evaluated on the operands being accepted.
    always_comb begin
        shamt    = src2[SHAMT_W-1:0];
        add_w    = {1'b0, src1} + {1'b0, src2};
        sub_w    = {1'b0, src1} + {1'b0, ~src2} + (WIDTH+1)'(1);
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (ALU_control)
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_XOR:  alu_res = src1 ^ src2;
            OP_NOR:  alu_res = ~(src1 | src2);
            OP_NAND: alu_res = ~(src1 & src2);
            OP_SLL:  alu_res = src1 << shamt;
            OP_SRL:  alu_res = src1 >> shamt;
            OP_SRA:  alu_res = $signed(src1) >>> shamt;
            OP_SLT:  alu_res = WIDTH'($signed(src1) < $signed(src2));
            OP_SNE:  alu_res = sub_w[WIDTH-1:0];
            OP_ADD: begin
                alu_res  = add_w[WIDTH-1:0];
                alu_cout = add_w[WIDTH];
                alu_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                           (add_w[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res  = sub_w[WIDTH-1:0];
                alu_cout = sub_w[WIDTH];
                alu_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) &&
                           (sub_w[WIDTH-1] != src1[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
        alu_zero = (ALU_control == OP_SNE) ? (src1 != src2) : (alu_res == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == BUSY);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = new_iter ? BUSY : DONE;
            BUSY: if (finish) state_d = DONE;
            DONE: if (out_ready) state_d = accept ? (new_iter ? BUSY : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            count_q <= '0;
            op_q    <= ALU_control;
            if (!new_iter) begin
                result_q <= alu_res;
                zero_q   <= alu_zero;
                cout_q   <= alu_cout;
                ovf_q    <= alu_ovf;
            end
        end else if (state_q == BUSY) begin
            count_q <= count_q + CNT_W'(1);
            if (finish) begin
                result_q <= iter_res;
                zero_q   <= (iter_res == '0);
                cout_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
